// File: rtl/plot_decoder_pkg.sv
// Shared types and constants for the plot-stream decoder.
// Holds the FSM encoding, the colour codes and the pixel count of one full frame.
package plot_decoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [2:0] FG_COLOUR   = 3'b110;
  localparam logic [2:0] BG_COLOUR   = 3'b000;
  localparam int         GRID_PIXELS = 1024;

endpackage

// File: rtl/plot_decoder_if.sv
// Plot bus, clear, row-readback port and status flags of the plot decoder.
// The master side drives the plot stream and read requests; the slave side is the decoder.
interface plot_decoder_if;

  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        clear;
  logic        rd_req;
  logic [3:0]  rd_row;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        frame_valid;
  logic        frame_done;
  logic [10:0] pixel_count;
  logic        stray_err;
  logic        conflict_err;

  modport master (
    output x, y, colour, plot, clear, rd_req, rd_row,
    input  rd_data, rd_valid, busy, frame_valid, frame_done, pixel_count,
           stray_err, conflict_err
  );

  modport slave (
    input  x, y, colour, plot, clear, rd_req, rd_row,
    output rd_data, rd_valid, busy, frame_valid, frame_done, pixel_count,
           stray_err, conflict_err
  );

endinterface

// File: rtl/plot_decoder_cell_locate.sv
// cell_locate: maps a plot pixel to its grid cell and cell offset, one registered stage.
// Latency 1 cycle; no backpressure, a pixel is accepted every cycle plot is high.
module cell_locate
  import plot_decoder_pkg::*;
#(
  parameter int CELL_W = 10,
  parameter int CELL_H = 7,
  parameter int FILL   = 2,
  parameter int GRID   = 16,
  localparam int IW    = $clog2(GRID)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          plot,
  input  logic [7:0]    x,
  input  logic [6:0]    y,
  input  logic [2:0]    colour,
  output logic          vld,
  output logic          on_grid,
  output logic          origin,
  output logic [IW-1:0] col,
  output logic [IW-1:0] row,
  output logic [2:0]    colour_q
);

  localparam int NCOL = 255 / CELL_W;
  localparam int NROW = 127 / CELL_H;

  int   col_c, ox_c, row_c, oy_c;
  logic on_grid_c;

  // Comparator chain: the last threshold passed gives the quotient and remainder.
  always_comb begin
    col_c = 0;
    ox_c  = int'(x);
    for (int k = 1; k <= NCOL; k++) begin
      if (int'(x) >= k * CELL_W) begin
        col_c = k;
        ox_c  = int'(x) - k * CELL_W;
      end
    end
    row_c = 0;
    oy_c  = int'(y);
    for (int k = 1; k <= NROW; k++) begin
      if (int'(y) >= k * CELL_H) begin
        row_c = k;
        oy_c  = int'(y) - k * CELL_H;
      end
    end
    on_grid_c = (col_c < GRID) && (row_c < GRID) && (ox_c < FILL) && (oy_c < FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld      <= 1'b0;
      on_grid  <= 1'b0;
      origin   <= 1'b0;
      col      <= '0;
      row      <= '0;
      colour_q <= BG_COLOUR;
    end else if (clear) begin
      vld      <= 1'b0;
    end else begin
      vld <= plot;
      if (plot) begin
        on_grid  <= on_grid_c;
        origin   <= (ox_c == 0) && (oy_c == 0);
        col      <= IW'(col_c);
        row      <= IW'(row_c);
        colour_q <= colour;
      end
    end
  end

endmodule

// File: rtl/plot_decoder.sv
// plot_decoder: snoops the pixel-plot bus and rebuilds the 16x16 character grid; PLOT_DECODER_CHECK_EN adds stray/conflict checks.
// Plot-to-grid latency 2 cycles, read latency 2 cycles; never backpressures the plot bus.
module plot_decoder
  import plot_decoder_pkg::*;
#(
  parameter int CELL_W = 10,
  parameter int CELL_H = 7,
  parameter int GRID   = 16,
  parameter int FILL   = 2
) (
  input  logic           fastclock,
  input  logic           resetn,
  plot_decoder_if.slave  bus
);

  localparam int IW        = $clog2(GRID);
  localparam int CW        = $clog2(GRID_PIXELS + 1);
  localparam int FRAME_PIX = GRID * GRID * FILL * FILL;

  logic                      s1_vld, s1_on_grid, s1_origin;
  logic [IW-1:0]             s1_col, s1_row, bit_idx;
  logic [2:0]                s1_colour;
  logic                      accept, is_fg;
  logic [GRID-1:0][GRID-1:0] grid;

  state_t          state;
  logic [CW-1:0]   pix_cnt;
  logic            busy_q, frame_valid_q, frame_done_q;
  logic            rd_pend, rd_valid_q;
  logic [GRID-1:0] rd_buf, rd_data_q;

  cell_locate #(
    .CELL_W (CELL_W),
    .CELL_H (CELL_H),
    .FILL   (FILL),
    .GRID   (GRID)
  ) u_locate (
    .clk      (fastclock),
    .rst_n    (resetn),
    .clear    (bus.clear),
    .plot     (bus.plot),
    .x        (bus.x),
    .y        (bus.y),
    .colour   (bus.colour),
    .vld      (s1_vld),
    .on_grid  (s1_on_grid),
    .origin   (s1_origin),
    .col      (s1_col),
    .row      (s1_row),
    .colour_q (s1_colour)
  );

  // Column 0 is the MSB of a grid row.
  assign bit_idx = IW'(GRID - 1) - s1_col;
  assign is_fg   = (s1_colour == FG_COLOUR);
  assign accept  = s1_vld && s1_on_grid && !bus.clear;

  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      grid <= '0;
    end else if (bus.clear) begin
      grid <= '0;
    end else if (accept && s1_origin) begin
      grid[s1_row][bit_idx] <= is_fg;
    end
  end

  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      pix_cnt       <= '0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else if (bus.clear) begin
      state         <= S_IDLE;
      pix_cnt       <= '0;
      busy_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            state   <= S_CAPTURE;
            busy_q  <= 1'b1;
            pix_cnt <= CW'(1);
          end
          S_CAPTURE: begin
            if (pix_cnt == CW'(FRAME_PIX - 1)) begin
              state         <= S_DONE;
              busy_q        <= 1'b0;
              pix_cnt       <= '0;
              frame_done_q  <= 1'b1;
              frame_valid_q <= 1'b1;
            end else begin
              pix_cnt <= pix_cnt + CW'(1);
            end
          end
          S_DONE: begin
            state         <= S_CAPTURE;
            busy_q        <= 1'b1;
            frame_valid_q <= 1'b0;
            pix_cnt       <= CW'(1);
          end
          default: begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Row is snapshotted when the request is sampled, so a write landing on that edge is not seen.
  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      rd_pend    <= 1'b0;
      rd_buf     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_pend    <= bus.rd_req;
      rd_valid_q <= rd_pend;
      if (bus.rd_req) rd_buf    <= grid[bus.rd_row];
      if (rd_pend)    rd_data_q <= rd_buf;
    end
  end

`ifdef PLOT_DECODER_CHECK_EN
  logic stray_q, conflict_q, stored, bad_colour;

  assign stored     = grid[s1_row][bit_idx];
  assign bad_colour = !is_fg && (s1_colour != BG_COLOUR);

  always_ff @(posedge fastclock or negedge resetn) begin
    if (!resetn) begin
      stray_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else if (bus.clear) begin
      stray_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      if (s1_vld && !s1_on_grid) stray_q <= 1'b1;
      if (accept && (bad_colour || (!s1_origin && (stored != is_fg)))) conflict_q <= 1'b1;
    end
  end

  assign bus.stray_err    = stray_q;
  assign bus.conflict_err = conflict_q;
`else
  assign bus.stray_err    = 1'b0;
  assign bus.conflict_err = 1'b0;
`endif

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.busy        = busy_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.pixel_count = pix_cnt;

endmodule

// File: tb/tb_plot_decoder.sv
// Directed bench for plot_decoder: cell decode, full frame, stray/conflict flags, async reset, clear priority.
module tb_plot_decoder;
  import plot_decoder_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  plot_decoder_if bus ();

  plot_decoder dut (
    .fastclock (clk),
    .resetn    (resetn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

`ifdef PLOT_DECODER_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plot_px(input int px, input int py, input logic [2:0] c);
    bus.x      = 8'(px);
    bus.y      = 7'(py);
    bus.colour = c;
    bus.plot   = 1'b1;
    tick();
    bus.plot   = 1'b0;
  endtask

  task automatic read_row(input int r, output logic [15:0] d);
    bus.rd_req = 1'b1;
    bus.rd_row = 4'(r);
    tick();
    bus.rd_req = 1'b0;
    tick();
    check("rd_valid", 32'(bus.rd_valid), 32'd1);
    d = bus.rd_data;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  task automatic zero_check(input string p);
    check({p, "_rd_data"},     32'(bus.rd_data),      32'd0);
    check({p, "_rd_valid"},    32'(bus.rd_valid),     32'd0);
    check({p, "_busy"},        32'(bus.busy),         32'd0);
    check({p, "_frame_valid"}, 32'(bus.frame_valid),  32'd0);
    check({p, "_frame_done"},  32'(bus.frame_done),   32'd0);
    check({p, "_pixel_count"}, 32'(bus.pixel_count),  32'd0);
    check({p, "_stray"},       32'(bus.stray_err),    32'd0);
    check({p, "_conflict"},    32'(bus.conflict_err), 32'd0);
  endtask

  function automatic logic [15:0] frame_row(input int r);
    if (r == 0) return 16'h8889;
    if (r == 7) return 16'h9249;
    return 16'h0000;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [15:0] pat;
    int          fd_seen;

    bus.x = '0; bus.y = '0; bus.colour = '0; bus.plot = 1'b0;
    bus.clear = 1'b0; bus.rd_req = 1'b0; bus.rd_row = '0;

    // Reset state
    #2;
    zero_check("reset");
    tick();
    resetn = 1'b1;
    tick();

    // 1: one cell at col 3, row 2
    plot_px(30, 14, FG_COLOUR);
    plot_px(31, 14, FG_COLOUR);
    plot_px(30, 15, FG_COLOUR);
    plot_px(31, 15, FG_COLOUR);
    tick(); tick();
    check("t1_pixel_count", 32'(bus.pixel_count), 32'd4);
    check("t1_busy",        32'(bus.busy),        32'd1);
    check("t1_stray",       32'(bus.stray_err),   32'd0);
    check("t1_conflict",    32'(bus.conflict_err),32'd0);
    read_row(2, d);
    check("t1_row2", 32'(d), 32'h1000);
    tick();
    check("t1_rd_valid_pulse", 32'(bus.rd_valid), 32'd0);
    check("t1_rd_data_hold",   32'(bus.rd_data),  32'h1000);

    // 2: full frame
    do_clear();
    fd_seen = 0;
    for (int r = 0; r < 16; r++) begin
      pat = frame_row(r);
      for (int c = 0; c < 16; c++)
        for (int dy = 0; dy < 2; dy++)
          for (int dx = 0; dx < 2; dx++) begin
            plot_px(c * 10 + dx, r * 7 + dy, pat[15-c] ? FG_COLOUR : BG_COLOUR);
            fd_seen += int'(bus.frame_done);
          end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      fd_seen += int'(bus.frame_done);
    end
    check("t2_frame_done_count", 32'(fd_seen),          32'd1);
    check("t2_frame_valid",      32'(bus.frame_valid),  32'd1);
    check("t2_pixel_count",      32'(bus.pixel_count),  32'd0);
    check("t2_busy",             32'(bus.busy),         32'd0);
    check("t2_conflict",         32'(bus.conflict_err), 32'd0);
    read_row(0, d);
    check("t2_row0", 32'(d), 32'h8889);
    read_row(7, d);
    check("t2_row7", 32'(d), 32'h9249);
    read_row(3, d);
    check("t2_row3", 32'(d), 32'h0000);

    // 3: off-grid pixel
    plot_px(35, 3, FG_COLOUR);
    tick(); tick();
    check("t3_stray",       32'(bus.stray_err),   32'(CHK));
    check("t3_pixel_count", 32'(bus.pixel_count), 32'd0);
    check("t3_frame_valid", 32'(bus.frame_valid), 32'd1);
    check("t3_busy",        32'(bus.busy),        32'd0);
    read_row(0, d);
    check("t3_row0", 32'(d), 32'h8889);

    // 4: conflicting colour inside one cell
    do_clear();
    check("t4_stray_cleared", 32'(bus.stray_err), 32'd0);
    plot_px(30, 14, FG_COLOUR);
    plot_px(31, 14, BG_COLOUR);
    tick(); tick();
    check("t4_conflict",    32'(bus.conflict_err), 32'(CHK));
    check("t4_pixel_count", 32'(bus.pixel_count),  32'd2);
    read_row(2, d);
    check("t4_row2", 32'(d), 32'h1000);

    // 5: asynchronous reset mid-frame
    do_clear();
    for (int i = 0; i < 500; i++) begin
      int r, c, dy, dx;
      r  = i / 64;
      c  = (i / 4) % 16;
      dy = (i / 2) % 2;
      dx = i % 2;
      plot_px(c * 10 + dx, r * 7 + dy, FG_COLOUR);
    end
    tick(); tick();
    check("t5_pixel_count", 32'(bus.pixel_count), 32'd500);
    read_row(0, d);
    check("t5_row0_before", 32'(d), 32'hFFFF);
    #2;
    resetn = 1'b0;
    #1;
    zero_check("t5_async");
    resetn = 1'b1;
    tick();
    for (int r = 0; r < 16; r++) begin
      read_row(r, d);
      check("t5_row_zero", 32'(d), 32'd0);
    end

    // 6: clear discards in-flight pixels and wins over a same-cycle plot
    plot_px(0, 0, FG_COLOUR);
    tick(); tick();
    read_row(0, d);
    check("t6_row0_set", 32'(d), 32'h8000);
    do_clear();
    plot_px(0, 0, FG_COLOUR);
    do_clear();
    tick(); tick();
    read_row(0, d);
    check("t6_inflight_row0",  32'(d),               32'h0000);
    check("t6_inflight_count", 32'(bus.pixel_count), 32'd0);
    bus.clear = 1'b1;
    plot_px(0, 0, FG_COLOUR);
    bus.clear = 1'b0;
    tick(); tick();
    read_row(0, d);
    check("t6_row0",        32'(d),               32'h0000);
    check("t6_busy",        32'(bus.busy),        32'd0);
    check("t6_pixel_count", 32'(bus.pixel_count), 32'd0);
    check("t6_state",       32'(dut.state),       32'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/plot_decoder.md
Name: plot_decoder

Overview:
- Sink end of the pixel-plot interface (x, y, colour, plot) that the bitmap text writers drive toward the VGA adapter.
- Monitors the plot stream and decodes the 2x2 cell blocks back into a 16x16 one-bit character grid, which a readback port exposes.
- Tracks frame completion and flags malformed traffic.
- Sits in parallel with vga_adapter, on the same plot bus, for self-check and screen-state queries.

Parameters:
- CELL_W, 10, horizontal pixel pitch of a grid cell
- CELL_H, 7, vertical pixel pitch of a grid cell
- GRID, 16, cells per row and rows per grid
- FILL, 2, side length in pixels of the drawn block at each cell origin
- FG_COLOUR, 3'b110, colour that encodes a set bit; 3'b000 encodes a clear bit

Ports:
- fastclock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- x  in  8  plot x coordinate
- y  in  7  plot y coordinate
- colour  in  3  plot colour
- plot  in  1  pixel write strobe, one pixel per cycle
- clear  in  1  synchronous clear of grid, counters and flags
- rd_req  in  1  row read request
- rd_row  in  4  row to read
- rd_data  out  16  row bits; MSB = column 0
- rd_valid  out  1  rd_data valid, 1-cycle pulse
- busy  out  1  frame capture in progress
- frame_valid  out  1  a complete frame has been captured since the last clear or frame start
- frame_done  out  1  1-cycle pulse on frame completion
- pixel_count  out  11  accepted on-grid pixels in the current frame
- stray_err  out  1  sticky: off-grid plot seen
- conflict_err  out  1  sticky: inconsistent colour within one cell block

Behaviour:
- Reset (asynchronous, resetn=0): all outputs 0, all grid bits 0, FSM in S_IDLE. Reset may assert at any time, including mid-frame.
- Stage 1 (registered on plot):
  - col = x / CELL_W, ox = x - col*CELL_W.
  - row = y / CELL_H, oy = y - row*CELL_H.
  - Division uses the cell_locate sub-module: comparator chain, no divider IP.
  - On-grid means col < GRID, row < GRID, ox < FILL and oy < FILL.
- Stage 2 (update), for an on-grid pixel:
  - If ox=0 and oy=0: write grid[row][15-col] = (colour == FG_COLOUR).
  - Otherwise: compare against the stored bit; on mismatch set conflict_err.
  - A colour that is neither FG_COLOUR nor 0 is stored as 0 and sets conflict_err.
  - pixel_count increments.
- Off-grid pixels are not counted and set stray_err.
- Latency: a plot sampled at edge N is visible to a read whose rd_req is sampled at edge N+2 or later.
- Read port:
  - rd_req sampled at edge N gives rd_data and rd_valid=1 after edge N+1.
  - rd_data holds its value until the next read.
  - A same-row write completing at edge N is not reflected in that read.
- FSM:
  - S_IDLE -> S_CAPTURE on the first on-grid pixel.
  - In S_CAPTURE, when pixel_count reaches GRID*GRID*FILL*FILL (1024): pulse frame_done, set frame_valid, clear pixel_count to 0, go to S_DONE.
  - S_DONE -> S_CAPTURE on the next on-grid pixel, which clears frame_valid and counts as 1.
  - busy = (state == S_CAPTURE).
- Grid bits persist across frames and are overwritten only.
- clear:
  - Returns the FSM to S_IDLE and zeroes the grid, counters and flags.
  - Any pixel in stage 1 or 2 during clear is discarded.
  - If clear and plot arrive in the same cycle, clear wins.
- Arithmetic: pixel_count is 11 bits and never exceeds 1024. All comparisons are unsigned.

Optional Feature:
- Macro: PLOT_DECODER_CHECK_EN.
- With it defined: stray_err and conflict_err behave as specified.
- Without it:
  - Both error outputs are tied to 0.
  - No compare logic is built.
  - Non-origin pixels only increment pixel_count.
  - Off-grid pixels are silently ignored.

Decomposition:
- Shared package holds:
  - FSM state encoding S_IDLE, S_CAPTURE, S_DONE;
  - the FG_COLOUR and BG_COLOUR constants;
  - GRID_PIXELS = 1024.
- One natural sub-module, cell_locate: registered x/y to (col, ox, row, oy, on_grid), parameterised by CELL_W, CELL_H, FILL.

Test Plan:
1. Plot (30,14),(31,14),(30,15),(31,15) in colour 110, then read row 2 -> rd_data = 16'h1000, pixel_count = 4, busy = 1, no errors.
2. Stream a full 1024-pixel frame encoding row0 = 16'h8889 and row7 = 16'h9249, rest 0 -> frame_done pulses exactly once, frame_valid = 1, row0 reads 16'h8889, row7 reads 16'h9249, pixel_count = 0.
3. Plot (35,3) in colour 110 (macro on) -> stray_err = 1, pixel_count unchanged, grid unchanged. Same plot with macro off -> stray_err = 0.
4. Plot (30,14) in colour 110, then (31,14) in colour 000 -> conflict_err = 1, row 2 still reads 16'h1000.
5. Deassert resetn for 1 ns mid-frame with pixel_count = 500 -> all outputs 0 immediately without a clock edge; a subsequent read of every row gives 0.
6. Assert clear and plot (0,0) in colour 110 in the same cycle -> row 0 reads 16'h0000, state S_IDLE, busy = 0.
